// File: rtl/reg_list_sequencer_pkg.sv
// rtl/reg_list_sequencer_pkg.sv - shared types and constants for the register-list sequencer
package reg_list_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_STM  = 2'd2,
    OP_LDM  = 2'd3
  } list_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2
  } seq_state_t;

  localparam logic [3:0]  SP_ADDR    = 4'd13;
  localparam logic [3:0]  LR_ADDR    = 4'd14;
  localparam logic [3:0]  PC_ADDR    = 4'd15;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/reg_list_sequencer_priority_encoder_16.sv
// rtl/reg_list_sequencer_priority_encoder_16.sv - lowest-set-bit encoder over a 16-bit register mask
module reg_list_sequencer_priority_encoder_16 (
  input  logic [15:0] bits_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx_o   = 4'd0;
    valid_o = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (bits_i[i]) begin
        idx_o   = 4'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_list_sequencer.sv
// rtl/reg_list_sequencer.sv - PUSH/POP/STM/LDM transfer sequencer; REG_SEQ_PERF_CNT_EN adds stall_cycles_o
module reg_list_sequencer
  import reg_list_sequencer_pkg::*;
#(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int LIST_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [LIST_WIDTH-1:0] reg_list_i,
  input  logic                  extra_reg_i,
  input  logic [ADDR_WIDTH-1:0] base_reg_i,
  input  logic                  hold_i,
  output logic                  stall_o,
  output logic                  xfer_valid_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [WORD-1:0]       offset_o,
  output logic                  mem_write_en_o,
  output logic                  mem_read_en_o,
  output logic                  reg_write_en_o,
  output logic                  pc_load_o,
  output logic                  base_wb_o,
  output logic [ADDR_WIDTH-1:0] base_addr_o,
  output logic [WORD-1:0]       base_delta_o,
  output logic                  done_o
`ifdef REG_SEQ_PERF_CNT_EN
  ,
  output logic [WORD-1:0]       stall_cycles_o
`endif
);

  seq_state_t            state_q;
  list_op_t              op_q;
  logic [15:0]           list_q;
  logic [3:0]            count_q;
  logic [3:0]            index_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  base_in_list_q;

  logic                  stall_q;
  logic                  xfer_valid_q;
  logic [ADDR_WIDTH-1:0] reg_addr_q;
  logic [WORD-1:0]       offset_q;
  logic                  mem_wr_q;
  logic                  mem_rd_q;
  logic                  pc_load_q;
  logic                  base_wb_q;
  logic [ADDR_WIDTH-1:0] base_addr_q;
  logic [WORD-1:0]       base_delta_q;
  logic                  done_q;

  list_op_t              op_in;
  logic [15:0]           eff_list;
  logic [3:0]            eff_count;
  logic                  accept;
  logic [15:0]           pe_src;
  logic [3:0]            pe_idx;
  logic                  pe_valid;
  list_op_t              x_op;
  logic [3:0]            x_idx;
  logic [3:0]            x_cnt;
  logic                  load_xfer;

  assign op_in = list_op_t'(op_i);

  // PUSH may add LR and POP may add PC on top of the low-register list
  always_comb begin
    eff_list = 16'd0;
    eff_list[LIST_WIDTH-1:0] = reg_list_i;
    if (extra_reg_i && op_in == OP_PUSH) eff_list[LR_ADDR] = 1'b1;
    if (extra_reg_i && op_in == OP_POP)  eff_list[PC_ADDR] = 1'b1;
  end

  // Number of registers in the incoming list; at most 9, so 4 bits suffice
  always_comb begin
    eff_count = 4'd0;
    for (int i = 0; i < 16; i++) eff_count = eff_count + 4'(eff_list[i]);
  end

  // Accept gated by reset so the combinational stall cannot leak out during reset
  assign accept = reset_i && (state_q == IDLE) && start_i && !hold_i && (eff_list != 16'd0);

  // In IDLE the encoder looks at the incoming list to prepare the first transfer
  assign pe_src = (state_q == IDLE) ? eff_list : list_q;
  assign x_op   = (state_q == IDLE) ? op_in : op_q;
  assign x_idx  = (state_q == IDLE) ? 4'd0 : index_q;
  assign x_cnt  = (state_q == IDLE) ? eff_count : count_q;

  assign load_xfer = accept || ((state_q == XFER) && !hold_i && pe_valid);

  reg_list_sequencer_priority_encoder_16 u_penc (
    .bits_i  (pe_src),
    .idx_o   (pe_idx),
    .valid_o (pe_valid)
  );

  function automatic logic [WORD-1:0] xfer_offset(list_op_t op, logic [3:0] idx, logic [3:0] cnt);
    logic [WORD-1:0] up;
    logic [WORD-1:0] span;
    up   = WORD'(idx) * WORD'(WORD_BYTES);
    span = WORD'(cnt) * WORD'(WORD_BYTES);
    // PUSH pre-decrements SP, so its block sits below the base
    return (op == OP_PUSH) ? (up - span) : up;
  endfunction

  // Sequencer FSM; every output is registered here and only gated by hold afterwards
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q        <= IDLE;
      op_q           <= OP_PUSH;
      list_q         <= 16'd0;
      count_q        <= 4'd0;
      index_q        <= 4'd0;
      base_q         <= '0;
      base_in_list_q <= 1'b0;
      stall_q        <= 1'b0;
      xfer_valid_q   <= 1'b0;
      reg_addr_q     <= '0;
      offset_q       <= '0;
      mem_wr_q       <= 1'b0;
      mem_rd_q       <= 1'b0;
      pc_load_q      <= 1'b0;
      base_wb_q      <= 1'b0;
      base_addr_q    <= '0;
      base_delta_q   <= '0;
      done_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q           <= op_in;
            count_q        <= eff_count;
            base_q         <= (op_in == OP_PUSH || op_in == OP_POP) ? ADDR_WIDTH'(SP_ADDR) : base_reg_i;
            base_in_list_q <= eff_list[base_reg_i];
          end
        end
        XFER: begin
          if (!hold_i && !pe_valid) begin
            state_q      <= WB;
            stall_q      <= 1'b0;
            xfer_valid_q <= 1'b0;
            reg_addr_q   <= '0;
            offset_q     <= '0;
            mem_wr_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            pc_load_q    <= 1'b0;
            // LDM that reloads its own base must not also write it back
            base_wb_q    <= !(op_q == OP_LDM && base_in_list_q);
            base_addr_q  <= base_q;
            base_delta_q <= (op_q == OP_PUSH) ? -(WORD'(count_q) * WORD'(WORD_BYTES))
                                              : (WORD'(count_q) * WORD'(WORD_BYTES));
            done_q       <= 1'b1;
          end
        end
        WB: begin
          if (!hold_i) begin
            state_q      <= IDLE;
            base_wb_q    <= 1'b0;
            base_addr_q  <= '0;
            base_delta_q <= '0;
            done_q       <= 1'b0;
            list_q       <= 16'd0;
            count_q      <= 4'd0;
            index_q      <= 4'd0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (load_xfer) begin
        state_q      <= XFER;
        stall_q      <= 1'b1;
        xfer_valid_q <= 1'b1;
        reg_addr_q   <= ADDR_WIDTH'(pe_idx);
        offset_q     <= xfer_offset(x_op, x_idx, x_cnt);
        mem_wr_q     <= (x_op == OP_PUSH) || (x_op == OP_STM);
        mem_rd_q     <= (x_op == OP_POP) || (x_op == OP_LDM);
        pc_load_q    <= (x_op == OP_POP) && (pe_idx == PC_ADDR);
        list_q       <= pe_src & ~(16'h0001 << pe_idx);
        index_q      <= x_idx + 4'd1;
      end
    end
  end

  // A held WB cycle keeps fetch stalled until the done pulse can actually fire
  assign stall_o        = stall_q || accept || ((state_q == WB) && hold_i);
  assign xfer_valid_o   = xfer_valid_q;
  assign reg_addr_o     = reg_addr_q;
  assign offset_o       = offset_q;
  assign mem_write_en_o = mem_wr_q && !hold_i;
  assign mem_read_en_o  = mem_rd_q && !hold_i;
  assign reg_write_en_o = mem_rd_q && !hold_i;
  assign pc_load_o      = pc_load_q && !hold_i;
  assign base_wb_o      = base_wb_q && !hold_i;
  assign base_addr_o    = base_addr_q;
  assign base_delta_o   = base_delta_q;
  assign done_o         = done_q && !hold_i;

`ifdef REG_SEQ_PERF_CNT_EN
  logic [WORD-1:0] stall_cycles_q;

  // Saturating count of every cycle in which fetch/decode is held
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stall_cycles_q <= '0;
    end else if (stall_o && !(&stall_cycles_q)) begin
      stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
`else
  // Stall cycle counter not built
`endif

endmodule

// File: tb/tb_reg_list_sequencer.sv
// tb/tb_reg_list_sequencer.sv - directed self-checking bench for reg_list_sequencer
module tb_reg_list_sequencer;

  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_POP  = 2'd1;
  localparam logic [1:0] OP_STM  = 2'd2;
  localparam logic [1:0] OP_LDM  = 2'd3;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [7:0]  reg_list_i;
  logic        extra_reg_i;
  logic [3:0]  base_reg_i;
  logic        hold_i;
  logic        stall_o;
  logic        xfer_valid_o;
  logic [3:0]  reg_addr_o;
  logic [31:0] offset_o;
  logic        mem_write_en_o;
  logic        mem_read_en_o;
  logic        reg_write_en_o;
  logic        pc_load_o;
  logic        base_wb_o;
  logic [3:0]  base_addr_o;
  logic [31:0] base_delta_o;
  logic        done_o;
`ifdef REG_SEQ_PERF_CNT_EN
  logic [31:0] stall_cycles_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  reg_list_sequencer #(.WORD(32), .ADDR_WIDTH(4), .LIST_WIDTH(8)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .op_i           (op_i),
    .reg_list_i     (reg_list_i),
    .extra_reg_i    (extra_reg_i),
    .base_reg_i     (base_reg_i),
    .hold_i         (hold_i),
    .stall_o        (stall_o),
    .xfer_valid_o   (xfer_valid_o),
    .reg_addr_o     (reg_addr_o),
    .offset_o       (offset_o),
    .mem_write_en_o (mem_write_en_o),
    .mem_read_en_o  (mem_read_en_o),
    .reg_write_en_o (reg_write_en_o),
    .pc_load_o      (pc_load_o),
    .base_wb_o      (base_wb_o),
    .base_addr_o    (base_addr_o),
    .base_delta_o   (base_delta_o),
    .done_o         (done_o)
`ifdef REG_SEQ_PERF_CNT_EN
    ,
    .stall_cycles_o (stall_cycles_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk_i);
    #1;
  endtask

  task automatic expect_xfer(input string tag, input logic [3:0] addr, input logic [31:0] off,
                             input logic wr, input logic rd, input logic pcl);
    check_eq({tag, ".valid"}, 32'(xfer_valid_o), 32'd1);
    check_eq({tag, ".addr"}, 32'(reg_addr_o), 32'(addr));
    check_eq({tag, ".offset"}, offset_o, off);
    check_eq({tag, ".mem_wr"}, 32'(mem_write_en_o), 32'(wr));
    check_eq({tag, ".mem_rd"}, 32'(mem_read_en_o), 32'(rd));
    check_eq({tag, ".reg_wr"}, 32'(reg_write_en_o), 32'(rd));
    check_eq({tag, ".pc_load"}, 32'(pc_load_o), 32'(pcl));
    check_eq({tag, ".stall"}, 32'(stall_o), 32'd1);
    check_eq({tag, ".done"}, 32'(done_o), 32'd0);
  endtask

  task automatic expect_wb(input string tag, input logic wb, input logic [3:0] base, input logic [31:0] delta);
    check_eq({tag, ".valid"}, 32'(xfer_valid_o), 32'd0);
    check_eq({tag, ".base_wb"}, 32'(base_wb_o), 32'(wb));
    check_eq({tag, ".base_addr"}, 32'(base_addr_o), 32'(base));
    check_eq({tag, ".delta"}, base_delta_o, delta);
    check_eq({tag, ".done"}, 32'(done_o), 32'd1);
    check_eq({tag, ".stall"}, 32'(stall_o), 32'd0);
    check_eq({tag, ".mem_wr"}, 32'(mem_write_en_o), 32'd0);
  endtask

  task automatic expect_idle(input string tag);
    check_eq({tag, ".stall"}, 32'(stall_o), 32'd0);
    check_eq({tag, ".valid"}, 32'(xfer_valid_o), 32'd0);
    check_eq({tag, ".done"}, 32'(done_o), 32'd0);
    check_eq({tag, ".base_wb"}, 32'(base_wb_o), 32'd0);
    check_eq({tag, ".mem_wr"}, 32'(mem_write_en_o), 32'd0);
    check_eq({tag, ".mem_rd"}, 32'(mem_read_en_o), 32'd0);
  endtask

  // Present a list instruction for one cycle; returns just after the first transfer appears
  task automatic start_op(input string tag, input logic [1:0] op, input logic [7:0] lst,
                          input logic ex, input logic [3:0] base);
    start_i     = 1'b1;
    op_i        = op;
    reg_list_i  = lst;
    extra_reg_i = ex;
    base_reg_i  = base;
    #1;
    check_eq({tag, ".accept_stall"}, 32'(stall_o), 32'd1);
    check_eq({tag, ".accept_valid"}, 32'(xfer_valid_o), 32'd0);
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
  endtask

  initial begin
    reset_i     = 1'b0;
    start_i     = 1'b0;
    op_i        = 2'd0;
    reg_list_i  = 8'd0;
    extra_reg_i = 1'b0;
    base_reg_i  = 4'd0;
    hold_i      = 1'b0;
    next_cycle();
    next_cycle();
    expect_idle("reset");
    check_eq("reset.addr", 32'(reg_addr_o), 32'd0);
    check_eq("reset.offset", offset_o, 32'd0);
    check_eq("reset.delta", base_delta_o, 32'd0);
    reset_i = 1'b1;
    next_cycle();

    // PUSH {r0,r2,LR}
    start_op("push", OP_PUSH, 8'h05, 1'b1, 4'd0);
    expect_xfer("push.r0", 4'd0, 32'hFFFF_FFF4, 1'b1, 1'b0, 1'b0);
    next_cycle();
    expect_xfer("push.r2", 4'd2, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
    next_cycle();
    expect_xfer("push.lr", 4'd14, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    next_cycle();
    expect_wb("push.wb", 1'b1, 4'd13, 32'hFFFF_FFF4);
    next_cycle();
    expect_idle("push.after");
`ifdef REG_SEQ_PERF_CNT_EN
    check_eq("perf.stall_cycles", stall_cycles_o, 32'd4);
`endif

    // POP {r1,PC}, with a two-cycle hold in the writeback cycle
    start_op("pop", OP_POP, 8'h02, 1'b1, 4'd7);
    expect_xfer("pop.r1", 4'd1, 32'd0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    expect_xfer("pop.pc", 4'd15, 32'd4, 1'b0, 1'b1, 1'b1);
    next_cycle();
    hold_i = 1'b1;
    #1;
    check_eq("pop.wbhold.done", 32'(done_o), 32'd0);
    check_eq("pop.wbhold.base_wb", 32'(base_wb_o), 32'd0);
    check_eq("pop.wbhold.stall", 32'(stall_o), 32'd1);
    next_cycle();
    check_eq("pop.wbhold2.done", 32'(done_o), 32'd0);
    hold_i = 1'b0;
    #1;
    expect_wb("pop.wb", 1'b1, 4'd13, 32'd8);
    next_cycle();
    expect_idle("pop.after");

    // LDM r3!,{r3,r4}; a start arriving mid-sequence must be ignored
    start_op("ldm", OP_LDM, 8'h18, 1'b0, 4'd3);
    expect_xfer("ldm.r3", 4'd3, 32'd0, 1'b0, 1'b1, 1'b0);
    start_i    = 1'b1;
    op_i       = OP_PUSH;
    reg_list_i = 8'hFF;
    #1;
    check_eq("ldm.busy_start.addr", 32'(reg_addr_o), 32'd3);
    check_eq("ldm.busy_start.stall", 32'(stall_o), 32'd1);
    next_cycle();
    start_i = 1'b0;
    #1;
    expect_xfer("ldm.r4", 4'd4, 32'd4, 1'b0, 1'b1, 1'b0);
    next_cycle();
    expect_wb("ldm.wb", 1'b0, 4'd3, 32'd8);
    next_cycle();
    expect_idle("ldm.after");

    // STM r0!,{r1..r7} with a two-cycle hold on the second transfer
    start_op("stm", OP_STM, 8'hFE, 1'b0, 4'd0);
    expect_xfer("stm.r1", 4'd1, 32'd0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    expect_xfer("stm.r2", 4'd2, 32'd4, 1'b1, 1'b0, 1'b0);
    hold_i = 1'b1;
    #1;
    for (int h = 0; h < 2; h++) begin
      check_eq("stm.hold.mem_wr", 32'(mem_write_en_o), 32'd0);
      check_eq("stm.hold.addr", 32'(reg_addr_o), 32'd2);
      check_eq("stm.hold.offset", offset_o, 32'd4);
      check_eq("stm.hold.stall", 32'(stall_o), 32'd1);
      if (h == 0) next_cycle();
    end
    hold_i = 1'b0;
    #1;
    expect_xfer("stm.r2.release", 4'd2, 32'd4, 1'b1, 1'b0, 1'b0);
    for (int r = 3; r <= 7; r++) begin
      next_cycle();
      expect_xfer("stm.rn", 4'(r), 32'((r - 1) * 4), 1'b1, 1'b0, 1'b0);
    end
    next_cycle();
    expect_wb("stm.wb", 1'b1, 4'd0, 32'd28);
    next_cycle();
    expect_idle("stm.after");

    // Reset during the second transfer of PUSH {r0,r2,LR}
    start_op("rst", OP_PUSH, 8'h05, 1'b1, 4'd0);
    expect_xfer("rst.r0", 4'd0, 32'hFFFF_FFF4, 1'b1, 1'b0, 1'b0);
    next_cycle();
    expect_xfer("rst.r2", 4'd2, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
    reset_i = 1'b0;
    #1;
    expect_idle("rst.now");
    check_eq("rst.now.addr", 32'(reg_addr_o), 32'd0);
    check_eq("rst.now.offset", offset_o, 32'd0);
    next_cycle();
    check_eq("rst.held.base_wb", 32'(base_wb_o), 32'd0);
    reset_i = 1'b1;
    #1;
    expect_idle("rst.release");
    next_cycle();
    expect_idle("rst.no_wb");
    start_op("push7", OP_PUSH, 8'h80, 1'b0, 4'd0);
    expect_xfer("push7.r7", 4'd7, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    next_cycle();
    expect_wb("push7.wb", 1'b1, 4'd13, 32'hFFFF_FFFC);
    next_cycle();
    expect_idle("push7.after");

    // Empty lists: PUSH with nothing, and STM whose extra bit must be ignored
    start_i     = 1'b1;
    op_i        = OP_PUSH;
    reg_list_i  = 8'h00;
    extra_reg_i = 1'b0;
    #1;
    check_eq("empty.push.stall", 32'(stall_o), 32'd0);
    next_cycle();
    expect_idle("empty.push.next");
    op_i        = OP_STM;
    extra_reg_i = 1'b1;
    #1;
    check_eq("empty.stm.stall", 32'(stall_o), 32'd0);
    next_cycle();
    expect_idle("empty.stm.next");
    start_i = 1'b0;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_list_sequencer.md
Name: reg_list_sequencer

Overview:
- Multi-cycle sequencer for Thumb register-list instructions (PUSH, POP, STMIA, LDMIA) in the decode stage.
- On accept, it stalls fetch/decode and emits one register transfer per cycle: register address, signed byte offset from base, and memory/regfile enables.
- It then issues one base-register writeback cycle.
- It feeds the decode/execute register in place of the single-cycle controller outputs.

Parameters:
- WORD, 32, datapath width
- ADDR_WIDTH, 4, register address width
- LIST_WIDTH, 8, low-register list bits (r0-r7)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- start_i  in  1  decoded register-list instruction valid in decode
- op_i  in  2  list_op_t: OP_PUSH=0, OP_POP=1, OP_STM=2, OP_LDM=3
- reg_list_i  in  LIST_WIDTH  register list bits
- extra_reg_i  in  1  PUSH: include LR (r14); POP: include PC (r15); ignored for STM/LDM
- base_reg_i  in  ADDR_WIDTH  base register (r13 forced for PUSH/POP)
- hold_i  in  1  downstream stall; freezes sequencer
- stall_o  out  1  hold fetch/decode
- xfer_valid_o  out  1  transfer cycle active
- reg_addr_o  out  ADDR_WIDTH  register transferred this cycle
- offset_o  out  WORD  signed byte offset from base, two's complement
- mem_write_en_o  out  1  store transfer
- mem_read_en_o  out  1  load transfer
- reg_write_en_o  out  1  load result to reg_addr_o
- pc_load_o  out  1  this transfer loads PC
- base_wb_o  out  1  base writeback cycle
- base_addr_o  out  ADDR_WIDTH  base register for writeback
- base_delta_o  out  WORD  signed writeback delta
- done_o  out  1  one-cycle pulse in final cycle

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, internal list/count/index cleared.
- A reset asserted mid-operation abandons the sequence; no writeback occurs.
- States: IDLE, XFER, WB.
- IDLE accept condition: start_i=1, hold_i=0, and effective list nonzero.
  - Effective list = reg_list_i plus bit 14 (PUSH with extra) or bit 15 (POP with extra).
  - On accept: latch op, list, and base (r13 for PUSH/POP); count = popcount (1..9, 4 bits); index = 0; go XFER.
  - stall_o=1 combinationally in the accept cycle.
- Empty effective list: start_i ignored, no stall, stays IDLE.
- start_i while not IDLE: ignored; decode holds the instruction.
- XFER, each unheld cycle:
  - Emit the lowest set remaining bit as reg_addr_o, then clear that bit and increment index.
  - offset_o = 4*index for POP/STM/LDM; 4*index - 4*count for PUSH.
  - Transfers go in ascending register order, so the lowest register is at the lowest address.
  - mem_write_en_o=1 for PUSH/STM; mem_read_en_o=reg_write_en_o=1 for POP/LDM.
  - pc_load_o=1 when reg_addr_o=15 on POP.
  - stall_o=1.
  - After the last bit is emitted, go WB.
- First transfer occurs one cycle after accept. Total occupancy is count+1 cycles after accept.
- WB:
  - base_wb_o=1; base_delta_o = -4*count for PUSH, +4*count otherwise.
  - LDM with the base register in the list: base_wb_o=0, which suppresses writeback.
  - done_o=1, stall_o=0 (fetch advances on this edge); next state IDLE.
- hold_i=1 in XFER/WB:
  - State, index, and list are frozen; reg_addr_o/offset_o hold.
  - All enables (mem/reg/pc/base_wb/done) are forced 0; stall_o stays 1.
- Outputs are Moore from registered state except stall_o in IDLE.

Optional Feature:
- Macro REG_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles_o [WORD-1:0], counting every cycle with stall_o=1, saturating at all-ones.
  - Cleared only by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package in GENERAL_DEFS.svh: list_op_t enum, seq_state_t enum (IDLE/XFER/WB), constants SP_ADDR=13, LR_ADDR=14, PC_ADDR=15, WORD_BYTES=4.
- One natural sub-module: priority_encoder_16, combinational, giving the lowest set bit index and a valid flag. The popcount stays inline.

Test Plan:
1. PUSH {r0,r2,LR} (list 0x05, extra=1):
   - Transfers r0/-12, r2/-8, r14/-4 with mem_write_en_o.
   - Then WB with base_addr_o=13, base_delta_o=-12, done_o.
   - stall_o high for 4 cycles.
2. POP {r1,PC} (0x02, extra=1): r1/+0, r15/+4 with pc_load_o on the second transfer; WB delta=+8.
3. LDM r3!,{r3,r4} (0x18, base 3): transfers r3/+0, r4/+4; WB cycle has base_wb_o=0, done_o=1.
4. STM r0!,{r1..r7} with hold_i pulsed 2 cycles mid-transfer:
   - No enables while held; no transfer skipped or duplicated.
   - WB delta=+28.
5. Reset pulled low during the second transfer of case 1: outputs 0 immediately; IDLE; new PUSH {r7} accepted afterwards with offset -4.
6. start_i with list 0x00, extra=0: no stall, no transfer; stays IDLE. With REG_SEQ_PERF_CNT_EN defined, after case 1, stall_cycles_o=4.
